apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB responder (completer) for the APB master interface. It decodes one select line, inserts a parameterised number of wait states, and serves a small 32-bit register file.
- The register file holds a read-only ID register, general RW registers, an interrupt enable register and a W1C interrupt status register.
- Sits on the APB bus as a verification slave model target and as a reusable peripheral register bank. Drives an aggregated interrupt output.

Parameters:
- PADDR_WIDTH, 32, address bus width.
- PDATA_WIDTH, 32, read and write data width; also the register width.
- NUM_REGS, 16, number of registers (min 4).
- BASE_ADDR, 0, byte base address of register 0 (word aligned).
- WAIT_STATES, 1, access-phase cycles with pready low before completion (0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- pclock  input  1  APB clock; all logic on rising edge.
- preset  input  1  synchronous active-low reset.
- psel  input  1  this slave's select bit (one bit of the master's psel[15:0]).
- penable  input  1  access phase indicator.
- prwd  input  1  1 = write, 0 = read.
- paddr  input  PADDR_WIDTH  byte address.
- pwdata  input  PDATA_WIDTH  write data.
- prdata  output  PDATA_WIDTH  read data, valid only when pready=1.
- pready  output  1  transfer completion.
- pslverr  output  1  error response, valid only when pready=1.
- int_set  input  PDATA_WIDTH  per-bit set pulses into INT_STAT.
- int_out  output  1  level interrupt, |(INT_STAT & INT_EN).

Behaviour:
- Reset is synchronous and active-low: preset sampled low at a pclock edge resets the state.
  - FSM -> IDLE; all registers 0 except ID.
  - prdata=0, pready=0, pslverr=0, int_out=0.
  - A transfer in flight is abandoned with no write.
- FSM states IDLE, WAIT, DONE. pready, prdata and pslverr are registered, and are nonzero only in DONE.
- IDLE: on an edge with psel=1 and penable=0 (setup phase):
  - Latch paddr, prwd and pwdata.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT, or to DONE if WAIT_STATES=0.
- WAIT: pready=0. Counter decrements each edge; at count 1 -> DONE.
  - If psel drops in WAIT (protocol violation): -> IDLE, no write, no response.
- DONE: pready=1 for exactly one cycle, then -> IDLE.
  - Back-to-back setups are accepted in the cycle after DONE.
- Latency: the first access cycle (penable=1) is numbered 1. pready is high in access cycle WAIT_STATES+1.
- Decode: off = latched paddr - BASE_ADDR; idx = off>>2.
  - Error if off[1:0]!=0, paddr<BASE_ADDR, or idx>=NUM_REGS.
  - On error: pslverr=1, prdata=0, no state change.
- Register map:
  - idx 0 ID: read-only, reads ID_VALUE; a write gives pslverr=1 with no effect.
  - idx 1..NUM_REGS-3: RW.
  - idx NUM_REGS-2 INT_EN: RW.
  - idx NUM_REGS-1 INT_STAT: read returns status; a write clears each bit written as 1 (W1C).
- Write commit happens on the edge entering DONE. A read in the following transfer returns the new value.
- Read data is sampled from the register file on the edge entering DONE.
- INT_STAT update each edge: stat <= (stat & ~clr) | int_set.
  - If int_set and a W1C clear hit the same bit on the same edge, set wins.
- int_out is registered: one cycle after INT_STAT/INT_EN change.
- pslverr=0 on every successful transfer.
- psel=1 with penable=1 while in IDLE (no setup seen) is ignored.

Test Plan:
- Reset, then WAIT_STATES=1: write 32'hDEAD_BEEF to BASE_ADDR+4, then read it.
  - pready low in access cycle 1, high in cycle 2.
  - Read returns 32'hDEAD_BEEF; pslverr=0 on both transfers.
- Read idx 0 -> prdata=32'hA5B0_0001.
  - Write 32'h0 to idx 0 -> pslverr=1.
  - Re-read still returns 32'hA5B0_0001.
- Error cases, each -> pslverr=1, prdata=0, registers unchanged:
  - paddr=BASE_ADDR+2 (misaligned).
  - paddr=BASE_ADDR+NUM_REGS*4 (out of range).
- Interrupts:
  - INT_EN=32'h1; pulse int_set=32'h1 -> int_out=1 one cycle later.
  - Write 32'h1 to INT_STAT -> int_out=0.
  - W1C on the same edge as an int_set pulse -> bit stays 1.
- Back-to-back transfers with WAIT_STATES=0:
  - Three writes then three reads with no idle cycles.
  - pready high in the first access cycle of each; all data matches.
- Reset mid-operation:
  - preset low during WAIT of a write to idx 3 -> idx 3 reads 0 afterwards; pready/pslverr 0 during reset.
  - psel dropped in WAIT -> no write, pready never asserted.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between an APB master and apb_slave_regfile.
// Widths must match the parameters of the attached slave.
interface apb_slave_regfile_if #(
  parameter int PADDR_WIDTH = 32,
  parameter int PDATA_WIDTH = 32
);
  logic                   psel;
  logic                   penable;
  logic                   prwd;
  logic [PADDR_WIDTH-1:0] paddr;
  logic [PDATA_WIDTH-1:0] pwdata;
  logic [PDATA_WIDTH-1:0] prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, prwd, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, prwd, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states serving an ID register, RW registers,
// an interrupt enable register and a W1C interrupt status register.
module apb_slave_regfile #(
  parameter int                     PADDR_WIDTH = 32,
  parameter int                     PDATA_WIDTH = 32,
  parameter int                     NUM_REGS    = 16,
  parameter int unsigned            BASE_ADDR   = 0,
  parameter int                     WAIT_STATES = 1,
  parameter logic [PDATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                   pclock,
  input  logic                   preset,
  apb_slave_regfile_if.slave     bus,
  input  logic [PDATA_WIDTH-1:0] int_set,
  output logic                   int_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int INT_EN_IDX   = NUM_REGS - 2;
  localparam int INT_STAT_IDX = NUM_REGS - 1;

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [PADDR_WIDTH-1:0] r_addr;
  logic                   r_wr;
  logic [PDATA_WIDTH-1:0] r_wdata;
  logic [PDATA_WIDTH-1:0] r_regs [1:NUM_REGS-2];
  logic [PDATA_WIDTH-1:0] r_intStat;
  logic [PDATA_WIDTH-1:0] r_prdata;
  logic                   r_pready;
  logic                   r_pslverr;
  logic                   r_intOut;

  logic                   w_setup;
  logic                   w_goDone;
  logic [PADDR_WIDTH-1:0] w_curAddr;
  logic                   w_curWr;
  logic [PDATA_WIDTH-1:0] w_curWdata;
  logic [PADDR_WIDTH-1:0] w_off;
  logic [PADDR_WIDTH-1:0] w_idx;
  logic                   w_err;
  logic [PDATA_WIDTH-1:0] w_rdata;
  logic [PDATA_WIDTH-1:0] w_clr;

  assign w_setup = bus.psel && !bus.penable;

  // With zero wait states the transfer completes on the setup edge itself,
  // so decode must look at the live bus rather than the not-yet-latched copy.
  assign w_curAddr  = (r_state == S_IDLE) ? bus.paddr  : r_addr;
  assign w_curWr    = (r_state == S_IDLE) ? bus.prwd   : r_wr;
  assign w_curWdata = (r_state == S_IDLE) ? bus.pwdata : r_wdata;

  assign w_goDone = ((r_state == S_IDLE) && w_setup && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && bus.psel && (r_cnt == 4'd1));

  assign w_off = w_curAddr - PADDR_WIDTH'(BASE_ADDR);
  assign w_idx = w_off >> 2;

  always_comb begin
    w_err = (w_off[1:0] != 2'b00) ||
            (w_curAddr < PADDR_WIDTH'(BASE_ADDR)) ||
            (w_idx >= PADDR_WIDTH'(NUM_REGS)) ||
            (w_curWr && (w_idx == '0));
    w_rdata = '0;
    if (w_idx == '0) w_rdata = ID_VALUE;
    for (int i = 1; i <= NUM_REGS - 2; i++) begin
      if (w_idx == PADDR_WIDTH'(i)) w_rdata = r_regs[i];
    end
    if (w_idx == PADDR_WIDTH'(INT_STAT_IDX)) w_rdata = r_intStat;
    w_clr = '0;
    if (w_goDone && !w_err && w_curWr && (w_idx == PADDR_WIDTH'(INT_STAT_IDX)))
      w_clr = w_curWdata;
  end

  always_ff @(posedge pclock) begin
    if (!preset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_intStat <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_intOut  <= 1'b0;
      for (int i = 1; i <= NUM_REGS - 2; i++) r_regs[i] <= '0;
    end else begin
      // Set has priority over a simultaneous W1C clear of the same bit.
      r_intStat <= (r_intStat & ~w_clr) | int_set;
      r_intOut  <= |(r_intStat & r_regs[INT_EN_IDX]);
      r_pready  <= w_goDone;
      r_pslverr <= w_goDone && w_err;
      r_prdata  <= (w_goDone && !w_err && !w_curWr) ? w_rdata : '0;
      if (w_goDone && !w_err && w_curWr) begin
        for (int i = 1; i <= NUM_REGS - 2; i++) begin
          if (w_idx == PADDR_WIDTH'(i)) r_regs[i] <= w_curWdata;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_addr  <= bus.paddr;
            r_wr    <= bus.prwd;
            r_wdata <= bus.pwdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.psel)          r_state <= S_IDLE;
          else if (r_cnt == 4'd1) r_state <= S_DONE;
          else                    r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign int_out     = r_intOut;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: one instance with one wait state,
// one with zero wait states, sharing clock, reset and interrupt set pulses.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expCycles;
  } txn_t;

  logic        pclock = 1'b0;
  logic        preset = 1'b0;
  logic [31:0] intSet = '0;
  logic        intOutA;
  logic        intOutB;
  int          assertions = 0;
  int          failures = 0;
  txn_t        sb[$];

  always #5 pclock = ~pclock;

  apb_slave_regfile_if #(.PADDR_WIDTH(32), .PDATA_WIDTH(32)) busA();
  apb_slave_regfile_if #(.PADDR_WIDTH(32), .PDATA_WIDTH(32)) busB();

  apb_slave_regfile #(.WAIT_STATES(1)) dutA (
    .pclock(pclock), .preset(preset), .bus(busA), .int_set(intSet), .int_out(intOutA)
  );

  apb_slave_regfile #(.WAIT_STATES(0)) dutB (
    .pclock(pclock), .preset(preset), .bus(busB), .int_set(intSet), .int_out(intOutB)
  );

  function automatic txn_t mk(string n, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] expRdata, logic expErr, int expCycles);
    txn_t t;
    t.name = n; t.wr = wr; t.addr = addr; t.wdata = wdata;
    t.expRdata = expRdata; t.expErr = expErr; t.expCycles = expCycles;
    return t;
  endfunction

  task automatic driveBus(input int d, input logic sel, input logic en, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    busA.psel = (d == 0) && sel;
    busB.psel = (d == 1) && sel;
    busA.penable = en; busB.penable = en;
    busA.prwd = wr;    busB.prwd = wr;
    busA.paddr = addr; busB.paddr = addr;
    busA.pwdata = wdata; busB.pwdata = wdata;
  endtask

  task automatic idle(input int n);
    driveBus(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (n) begin
      @(posedge pclock); #1;
    end
  endtask

  // Runs one transfer; cycles is the access cycle with pready high, -1 on timeout.
  task automatic apbXfer(input int d, input txn_t t, output logic [31:0] rdata,
                         output logic err, output int cycles);
    bit done = 0;
    rdata = '0; err = 1'b0; cycles = -1;
    driveBus(d, 1'b1, 1'b0, t.wr, t.addr, t.wdata);
    @(posedge pclock); #1;
    driveBus(d, 1'b1, 1'b1, t.wr, t.addr, t.wdata);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge pclock);
      if ((d == 0) ? busA.pready : busB.pready) begin
        rdata  = (d == 0) ? busA.prdata : busB.prdata;
        err    = (d == 0) ? busA.pslverr : busB.pslverr;
        cycles = c;
        done   = 1;
      end
      @(posedge pclock); #1;
    end
  endtask

  task automatic test_reset();
    preset = 1'b0;
    idle(3);
    @(negedge pclock);
    assertions++;
    if (busA.pready !== 1'b0 || busB.pready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pready got %b/%b want 0/0", busA.pready, busB.pready);
    end
    assertions++;
    if (busA.pslverr !== 1'b0 || busB.pslverr !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pslverr got %b/%b want 0/0", busA.pslverr, busB.pslverr);
    end
    assertions++;
    if (busA.prdata !== 32'h0 || busB.prdata !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_prdata got %h/%h want 0", busA.prdata, busB.prdata);
    end
    assertions++;
    if (intOutA !== 1'b0 || intOutB !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_int_out got %b/%b want 0/0", intOutA, intOutB);
    end
    @(posedge pclock); #1;
    preset = 1'b1;
    idle(1);
  endtask

  task automatic runTable(input int d, input txn_t tbl[$]);
    txn_t e; logic [31:0] rd; logic er; int cy;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      apbXfer(d, tbl[i], rd, er, cy);
      e = sb.pop_front();
      assertions++;
      if (rd !== e.expRdata) begin
        failures++; $display("[TB] FAIL %s prdata got %h want %h", e.name, rd, e.expRdata);
      end
      assertions++;
      if (er !== e.expErr) begin
        failures++; $display("[TB] FAIL %s pslverr got %b want %b", e.name, er, e.expErr);
      end
      assertions++;
      if (cy !== e.expCycles) begin
        failures++; $display("[TB] FAIL %s ready_cycle got %0d want %0d", e.name, cy, e.expCycles);
      end
    end
  endtask

  task automatic test_read_write();
    txn_t tbl[$];
    tbl.push_back(mk("rw_write", 1'b1, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b0, 2));
    tbl.push_back(mk("rw_read",  1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
  endtask

  task automatic test_id_reg();
    txn_t tbl[$];
    tbl.push_back(mk("id_read",   1'b0, 32'h0, 32'h0, 32'hA5B0_0001, 1'b0, 2));
    tbl.push_back(mk("id_write",  1'b1, 32'h0, 32'h0, 32'h0,         1'b1, 2));
    tbl.push_back(mk("id_reread", 1'b0, 32'h0, 32'h0, 32'hA5B0_0001, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
  endtask

  task automatic test_decode_errors();
    txn_t tbl[$];
    tbl.push_back(mk("misalign_rd", 1'b0, 32'h2,  32'h0,         32'h0, 1'b1, 2));
    tbl.push_back(mk("misalign_wr", 1'b1, 32'h6,  32'hFFFF_FFFF, 32'h0, 1'b1, 2));
    tbl.push_back(mk("range_rd",    1'b0, 32'h40, 32'h0,         32'h0, 1'b1, 2));
    tbl.push_back(mk("range_wr",    1'b1, 32'h40, 32'h1234_5678, 32'h0, 1'b1, 2));
    tbl.push_back(mk("err_noeffect", 1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
  endtask

  task automatic test_interrupts();
    txn_t tbl[$];
    tbl.push_back(mk("int_en_wr", 1'b1, 32'h38, 32'h1, 32'h0, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
    intSet = 32'h1;
    @(posedge pclock); #1;
    intSet = 32'h0;
    @(negedge pclock);
    assertions++;
    if (intOutA !== 1'b0) begin
      failures++; $display("[TB] FAIL int_out_early got %b want 0", intOutA);
    end
    @(posedge pclock); #1;
    @(negedge pclock);
    assertions++;
    if (intOutA !== 1'b1) begin
      failures++; $display("[TB] FAIL int_out_set got %b want 1", intOutA);
    end
    tbl.delete();
    tbl.push_back(mk("stat_read1", 1'b0, 32'h3C, 32'h0, 32'h1, 1'b0, 2));
    tbl.push_back(mk("stat_w1c",   1'b1, 32'h3C, 32'h1, 32'h0, 1'b0, 2));
    tbl.push_back(mk("stat_read0", 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
    @(negedge pclock);
    assertions++;
    if (intOutA !== 1'b0) begin
      failures++; $display("[TB] FAIL int_out_clear got %b want 0", intOutA);
    end
    @(posedge pclock); #1;
  endtask

  task automatic test_set_wins();
    txn_t tbl[$];
    driveBus(1, 1'b1, 1'b0, 1'b1, 32'h3C, 32'h1);
    intSet = 32'h1;
    @(posedge pclock); #1;
    intSet = 32'h0;
    driveBus(1, 1'b1, 1'b1, 1'b1, 32'h3C, 32'h1);
    @(negedge pclock);
    assertions++;
    if (busB.pready !== 1'b1 || busB.pslverr !== 1'b0) begin
      failures++; $display("[TB] FAIL setwins_resp got %b/%b want 1/0", busB.pready, busB.pslverr);
    end
    @(posedge pclock); #1;
    tbl.push_back(mk("setwins_read", 1'b0, 32'h3C, 32'h0, 32'h1, 1'b0, 1));
    runTable(1, tbl);
    idle(1);
  endtask

  task automatic test_back_to_back();
    txn_t tbl[$];
    tbl.push_back(mk("b2b_w1", 1'b1, 32'h4, 32'h0000_1111, 32'h0, 1'b0, 1));
    tbl.push_back(mk("b2b_w2", 1'b1, 32'h8, 32'h2222_0000, 32'h0, 1'b0, 1));
    tbl.push_back(mk("b2b_w3", 1'b1, 32'hC, 32'h3333_3333, 32'h0, 1'b0, 1));
    tbl.push_back(mk("b2b_r1", 1'b0, 32'h4, 32'h0, 32'h0000_1111, 1'b0, 1));
    tbl.push_back(mk("b2b_r2", 1'b0, 32'h8, 32'h0, 32'h2222_0000, 1'b0, 1));
    tbl.push_back(mk("b2b_r3", 1'b0, 32'hC, 32'h0, 32'h3333_3333, 1'b0, 1));
    runTable(1, tbl);
    idle(1);
  endtask

  task automatic test_reset_mid();
    txn_t tbl[$];
    tbl.push_back(mk("pre_wr3", 1'b1, 32'hC, 32'h1111_1111, 32'h0, 1'b0, 2));
    tbl.push_back(mk("pre_rd3", 1'b0, 32'hC, 32'h0, 32'h1111_1111, 1'b0, 2));
    runTable(0, tbl);
    driveBus(0, 1'b1, 1'b0, 1'b1, 32'hC, 32'hDEAD_DEAD);
    @(posedge pclock); #1;
    driveBus(0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hDEAD_DEAD);
    preset = 1'b0;
    @(posedge pclock); #1;
    @(negedge pclock);
    assertions++;
    if (busA.pready !== 1'b0 || busA.pslverr !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_resp got %b/%b want 0/0", busA.pready, busA.pslverr);
    end
    idle(1);
    preset = 1'b1;
    idle(1);
    tbl.delete();
    tbl.push_back(mk("post_rd3", 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 2));
    tbl.push_back(mk("post_rd1", 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
  endtask

  task automatic test_psel_drop();
    txn_t tbl[$];
    bit sawReady = 0;
    driveBus(0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h5555_5555);
    @(posedge pclock); #1;
    driveBus(0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h5555_5555);
    repeat (4) begin
      @(negedge pclock);
      if (busA.pready !== 1'b0) sawReady = 1;
      @(posedge pclock); #1;
    end
    assertions++;
    if (sawReady) begin
      failures++; $display("[TB] FAIL psel_drop_ready got 1 want 0");
    end
    tbl.push_back(mk("psel_drop_rd2", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 2));
    runTable(0, tbl);
    idle(1);
  endtask

  initial begin
    driveBus(0, 1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_read_write();
    test_id_reg();
    test_decode_errors();
    test_interrupts();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    test_psel_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
